ascii_term_writer: RTL and testbench

- Writer side of the text screen: consumes a stream of 7-bit ASCII codes and writes them into the external character buffer that the scanout/glyph path reads.
- Tracks the cursor and interprets CR, LF, BS and TAB.
- Scrolls by rotating a top-row offset and clearing the recycled row, so no bulk copy is ever needed.
- Sits between the host/UART byte source and the character RAM write port.

---
 rtl/ascii_term_writer.sv | 214 +++++++++++++++++++++
 tb/tb_ascii_term_writer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_term_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ascii_term_writer
// Purpose  : Writer side of the text screen. Consumes 7-bit ASCII codes,
//            tracks the cursor, interprets CR/LF/BS/TAB, and writes into the
//            external character buffer. Scrolling rotates top_row and clears
//            only the recycled physical row.
// Option   : ASCII_TERM_FF_CLEAR_EN - form feed (0x0C) clears the screen and
//            homes the cursor; otherwise 0x0C is swallowed.
// Revision : 1.0 - initial release
// ============================================================================
module ascii_term_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 6,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [6:0]        wr_char,
  output logic [ROW_W-1:0]  top_row,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row
);

  localparam logic [6:0]        SPACE      = 7'h20;
  localparam logic [6:0]        CODE_BS    = 7'h08;
  localparam logic [6:0]        CODE_TAB   = 7'h09;
  localparam logic [6:0]        CODE_LF    = 7'h0A;
  localparam logic [6:0]        CODE_CR    = 7'h0D;
`ifdef ASCII_TERM_FF_CLEAR_EN
  localparam logic [6:0]        CODE_FF    = 7'h0C;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_CLEAR = ADDR_W'(COLS - 1);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [ADDR_W-1:0]   clear_base, clear_base_nxt;
  logic                ready_nxt, wr_en_nxt;
  logic [ADDR_W-1:0]   wr_addr_nxt;
  logic [6:0]          wr_char_nxt;
  logic [ROW_W-1:0]    top_nxt, row_nxt;
  logic [COL_W-1:0]    col_nxt;

  logic                accept;
  logic [ROW_W:0]      row_sum;
  logic [ROW_W-1:0]    phys_row;
  logic [ADDR_W-1:0]   row_base;
  logic [COL_W:0]      tab_stop;
  logic                do_write, advance;
  logic [COL_W-1:0]    write_col;
  logic [6:0]          write_data;

  assign accept = char_valid && char_ready;

  // Cursor physical row and its buffer base; one subtract suffices since both terms are < ROWS
  always_comb begin
    row_sum  = {1'b0, top_row} + {1'b0, cursor_row};
    phys_row = (row_sum >= (ROW_W+1)'(ROWS)) ? ROW_W'(row_sum - (ROW_W+1)'(ROWS))
                                             : row_sum[ROW_W-1:0];
    row_base = ADDR_W'(phys_row) * ADDR_W'(COLS);
    tab_stop = ({1'b0, cursor_col} | (COL_W+1)'(7)) + (COL_W+1)'(1);
  end

  // Next-state and next-output logic for the INIT / IDLE / CLEAR sequencer
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    clear_base_nxt = clear_base;
    ready_nxt      = 1'b0;
    wr_en_nxt      = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_char_nxt    = wr_char;
    top_nxt        = top_row;
    col_nxt        = cursor_col;
    row_nxt        = cursor_row;
    do_write       = 1'b0;
    advance        = 1'b0;
    write_col      = cursor_col;
    write_data     = SPACE;

    case (state)
      ST_INIT: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = cnt;
        wr_char_nxt = SPACE;
        if (cnt == LAST_ADDR) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end

      ST_CLEAR: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = clear_base + cnt;
        wr_char_nxt = SPACE;
        if (cnt == LAST_CLEAR) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end

      default: begin
        ready_nxt = 1'b1;
        if (accept) begin
          if (char_in >= 7'h20 && char_in <= 7'h7E) begin
            do_write   = 1'b1;
            write_data = char_in;
            if (cursor_col < LAST_COL) begin
              col_nxt = cursor_col + COL_W'(1);
            end else begin
              col_nxt = '0;
              advance = 1'b1;
            end
          end else begin
            case (char_in)
              CODE_LF:  advance = 1'b1;
              CODE_CR:  col_nxt = '0;
              CODE_BS: begin
                if (cursor_col != '0) begin
                  col_nxt   = cursor_col - COL_W'(1);
                  write_col = cursor_col - COL_W'(1);
                  do_write  = 1'b1;
                end
              end
              CODE_TAB: col_nxt = (tab_stop > {1'b0, LAST_COL}) ? LAST_COL
                                                                : tab_stop[COL_W-1:0];
`ifdef ASCII_TERM_FF_CLEAR_EN
              CODE_FF: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
                ready_nxt = 1'b0;
                col_nxt   = '0;
                row_nxt   = '0;
                top_nxt   = '0;
              end
`endif
              default: ;
            endcase
          end

          // The write lands at the pre-scroll position
          if (do_write) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = row_base + ADDR_W'(write_col);
            wr_char_nxt = write_data;
          end

          // Bottom line reached: recycle the old top row instead of moving text
          if (advance) begin
            if (cursor_row < LAST_ROW) begin
              row_nxt = cursor_row + ROW_W'(1);
            end else begin
              top_nxt        = (top_row == LAST_ROW) ? '0 : top_row + ROW_W'(1);
              clear_base_nxt = ADDR_W'(top_row) * ADDR_W'(COLS);
              cnt_nxt        = '0;
              state_nxt      = ST_CLEAR;
              ready_nxt      = 1'b0;
            end
          end
        end
      end
    endcase
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      cnt        <= '0;
      clear_base <= '0;
      char_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_char    <= SPACE;
      top_row    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      clear_base <= clear_base_nxt;
      char_ready <= ready_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_char    <= wr_char_nxt;
      top_row    <= top_nxt;
      cursor_col <= col_nxt;
      cursor_row <= row_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascii_term_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ascii_term_writer
// Purpose  : Self-checking bench for ascii_term_writer: directed vector table,
//            hand-written corner sequences and random traffic, all compared
//            cycle by cycle against a screen-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascii_term_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 6;
  localparam int ADDR_W = 13;
  localparam int TOTAL  = COLS * ROWS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [6:0]        char_in = 7'h00;
  logic              char_valid = 1'b0;
  logic              char_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [6:0]        wr_char;
  logic [ROW_W-1:0]  top_row;
  logic [COL_W-1:0]  cursor_col;
  logic [ROW_W-1:0]  cursor_row;

  ascii_term_writer #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .top_row(top_row), .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  // Reference model: one slot per expected output cycle
  typedef struct { bit en; int addr; int ch; bit bulk; } slot_t;
  slot_t q[$];
  int    m_col, m_row, m_top, m_bulk, last_addr, last_char;
  bit    m_ready;
  int    vectors = 0;
  int    miscompares = 0;
  int    pulse_cnt = 0;

  typedef struct { int ch; int en; int addr; int wch; int col; int row; int top; int rdy; } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_bulk(input int base, input int n);
    for (int k = 0; k < n; k++) q.push_back('{1'b1, base + k, 32, 1'b1});
    m_bulk += n;
  endtask

  task automatic model_reset();
    q.delete();
    m_col = 0; m_row = 0; m_top = 0; m_bulk = 0;
    last_addr = 0; last_char = 32; m_ready = 1'b0;
    push_bulk(0, TOTAL);
  endtask

  function automatic bit advance_row();
    if (m_row < ROWS - 1) begin
      m_row++;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_accept(input int c);
    slot_t s;
    bit    scroll;
    int    prow, old_top;
    s = '{1'b0, 0, 0, 1'b0};
    scroll = 1'b0;
    prow = (m_top + m_row) % ROWS;
    if (c >= 32 && c <= 126) begin
      s.en = 1'b1; s.addr = prow * COLS + m_col; s.ch = c;
      if (m_col < COLS - 1) m_col++;
      else begin m_col = 0; scroll = advance_row(); end
    end else if (c == 10) begin
      scroll = advance_row();
    end else if (c == 13) begin
      m_col = 0;
    end else if (c == 8) begin
      if (m_col > 0) begin
        m_col--;
        s.en = 1'b1; s.addr = prow * COLS + m_col; s.ch = 32;
      end
    end else if (c == 9) begin
      m_col = (m_col / 8 + 1) * 8;
      if (m_col > COLS - 1) m_col = COLS - 1;
    end
`ifdef ASCII_TERM_FF_CLEAR_EN
    else if (c == 12) begin
      m_col = 0; m_row = 0; m_top = 0;
      q.push_back(s);
      push_bulk(0, TOTAL);
      return;
    end
`endif
    q.push_back(s);
    if (scroll) begin
      old_top = m_top;
      m_top = (m_top + 1) % ROWS;
      push_bulk(old_top * COLS, COLS);
    end
  endtask

  // One clock: apply accept/reset to the model, then compare every output
  task automatic tick(output bit acc);
    slot_t s;
    acc = char_valid && m_ready && !reset;
    @(posedge clk);
    if (reset) model_reset();
    else if (acc) model_accept(int'(char_in));
    #1;
    if (!reset) begin
      m_ready = (m_bulk == 0);
      if (q.size() > 0) begin
        s = q.pop_front();
        if (s.bulk) m_bulk--;
        if (s.en) begin last_addr = s.addr; last_char = s.ch; end
      end else begin
        s = '{1'b0, 0, 0, 1'b0};
      end
    end else begin
      s = '{1'b0, 0, 0, 1'b0};
    end
    if (wr_en) pulse_cnt++;
    check("char_ready", int'(char_ready), int'(m_ready));
    check("wr_en",      int'(wr_en),      int'(s.en));
    check("wr_addr",    int'(wr_addr),    last_addr);
    check("wr_char",    int'(wr_char),    last_char);
    check("top_row",    int'(top_row),    m_top);
    check("cursor_col", int'(cursor_col), m_col);
    check("cursor_row", int'(cursor_row), m_row);
  endtask

  task automatic step();
    bit a;
    tick(a);
  endtask

  task automatic send(input int c);
    bit a;
    int n;
    char_in = 7'(c);
    char_valid = 1'b1;
    a = 1'b0;
    n = 0;
    while (!a && n < 6000) begin
      tick(a);
      n++;
    end
    char_valid = 1'b0;
    check("send_accept", int'(a), 1);
  endtask

  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    while (!m_ready && n < bound) begin
      step();
      n++;
    end
    check("wait_ready", int'(m_ready), 1);
  endtask

  function automatic logic [6:0] pick_char();
    int r, x;
    r = $urandom_range(0, 15);
    case (r)
      0, 1: x = 10;
      2:    x = 13;
      3:    x = 8;
      4:    x = 9;
      5: begin
        x = $urandom_range(0, 31);
        if (x == 12) x = 0;
      end
      6:    x = 127;
      default: x = $urandom_range(32, 126);
    endcase
    return 7'(x);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit a, hold;
    int k;

    tbl[0]  = '{'h41, 1, 0,  'h41, 1, 0, 0, 1};
    tbl[1]  = '{'h42, 1, 1,  'h42, 2, 0, 0, 1};
    tbl[2]  = '{'h09, 0, 1,  'h42, 8, 0, 0, 1};
    tbl[3]  = '{'h08, 1, 7,  'h20, 7, 0, 0, 1};
    tbl[4]  = '{'h0D, 0, 7,  'h20, 0, 0, 0, 1};
    tbl[5]  = '{'h0A, 0, 7,  'h20, 0, 1, 0, 1};
    tbl[6]  = '{'h78, 1, 80, 'h78, 1, 1, 0, 1};
    tbl[7]  = '{'h7F, 0, 80, 'h78, 1, 1, 0, 1};
    tbl[8]  = '{'h01, 0, 80, 'h78, 1, 1, 0, 1};
    tbl[9]  = '{'h08, 1, 80, 'h20, 0, 1, 0, 1};
    tbl[10] = '{'h08, 0, 80, 'h20, 0, 1, 0, 1};
    tbl[11] = '{'h7E, 1, 80, 'h7E, 1, 1, 0, 1};
    tbl[12] = '{'h20, 1, 81, 'h20, 2, 1, 0, 1};
    tbl[13] = '{'h1B, 0, 81, 'h20, 2, 1, 0, 1};

    // Reset and power-up clear
    reset = 1'b1;
    step();
    reset = 1'b0;
    pulse_cnt = 0;
    wait_ready(6000);
    check("init_pulses", pulse_cnt, TOTAL);
    check("init_col", int'(cursor_col), 0);
    check("init_top", int'(top_row), 0);

    // Directed vector table, sent back to back
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].ch);
      check($sformatf("tbl%0d_wr_en", i),   int'(wr_en),      tbl[i].en);
      check($sformatf("tbl%0d_wr_addr", i), int'(wr_addr),    tbl[i].addr);
      check($sformatf("tbl%0d_wr_char", i), int'(wr_char),    tbl[i].wch);
      check($sformatf("tbl%0d_col", i),     int'(cursor_col), tbl[i].col);
      check($sformatf("tbl%0d_row", i),     int'(cursor_row), tbl[i].row);
      check($sformatf("tbl%0d_top", i),     int'(top_row),    tbl[i].top);
      check($sformatf("tbl%0d_ready", i),   int'(char_ready), tbl[i].rdy);
    end

    // Line wrap from the last column
    send(13);
    for (int i = 0; i < 4; i++) send(10);
    for (int i = 0; i < 79; i++) send('h61);
    check("wrap_col_before", int'(cursor_col), 79);
    send('h78);
    check("wrap_wr_en", int'(wr_en), 1);
    check("wrap_addr", int'(wr_addr), 479);
    check("wrap_char", int'(wr_char), 'h78);
    check("wrap_col", int'(cursor_col), 0);
    check("wrap_row", int'(cursor_row), 6);

    // Backspace down to column 0, then tabs
    send('h61); send('h62); send('h63);
    for (int i = 0; i < 3; i++) begin
      send(8);
      check($sformatf("bs%0d_wr_en", i), int'(wr_en), 1);
      check($sformatf("bs%0d_addr", i), int'(wr_addr), 480 + 2 - i);
      check($sformatf("bs%0d_char", i), int'(wr_char), 'h20);
    end
    send(8);
    check("bs3_wr_en", int'(wr_en), 0);
    check("bs3_col", int'(cursor_col), 0);
    send(9);
    check("tab0_col", int'(cursor_col), 8);
    send(13);
    for (int i = 0; i < 77; i++) send('h62);
    send(9);
    check("tab77_col", int'(cursor_col), 79);

    // Scroll at the bottom row
    send(13);
    for (int i = 0; i < 53; i++) send(10);
    check("bottom_row", int'(cursor_row), 59);
    send(10);
    check("scroll_top", int'(top_row), 1);
    check("scroll_row", int'(cursor_row), 59);
    check("scroll_ready", int'(char_ready), 0);
    k = 0;
    for (int n = 0; n < 200 && !char_ready; n++) begin
      step();
      if (wr_en) begin
        check($sformatf("clr%0d_addr", k), int'(wr_addr), k);
        check($sformatf("clr%0d_ready", k), int'(char_ready), 0);
        k++;
      end
    end
    check("clr_count", k, 80);

    // Reset in the middle of a row clear
    send(10);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    check("rst_addr", int'(wr_addr), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_char", int'(wr_char), 'h20);
    check("rst_top", int'(top_row), 0);
    check("rst_ready", int'(char_ready), 0);
    reset = 1'b0;
    pulse_cnt = 0;
    step();
    check("reinit_wr_en", int'(wr_en), 1);
    check("reinit_addr", int'(wr_addr), 0);
    wait_ready(6000);
    check("reinit_pulses", pulse_cnt, TOTAL);

    // Form feed
    send('h51);
    send(10);
    pulse_cnt = 0;
    send(12);
`ifdef ASCII_TERM_FF_CLEAR_EN
    check("ff_ready", int'(char_ready), 0);
    wait_ready(6000);
    check("ff_pulses", pulse_cnt, TOTAL);
    check("ff_col", int'(cursor_col), 0);
    check("ff_row", int'(cursor_row), 0);
    check("ff_top", int'(top_row), 0);
`else
    check("ff_wr_en", int'(wr_en), 0);
    check("ff_col", int'(cursor_col), 1);
    check("ff_row", int'(cursor_row), 1);
    check("ff_ready", int'(char_ready), 1);
`endif

    // Random traffic; the source holds a char until it is accepted
    hold = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!hold) begin
        char_valid = ($urandom_range(0, 3) != 0);
        char_in = pick_char();
      end
      tick(a);
      hold = char_valid && !a;
    end
    char_valid = 1'b0;
    wait_ready(6000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
